// File: rtl/cnn_pkg.sv
// ---------------------------------------------------------------------------
// cnn_pkg
// Shared constants and types for the CNN layer engines.
//   DATA_W / ADDR_W : pixel and memory address widths
//   CSEL_*          : memory-select codes for the layer memories
//   L*_DIM          : square map side lengths per layer
//   state_e         : control-state encoding used by the pooling stage
// ---------------------------------------------------------------------------
package cnn_pkg;

  localparam int DATA_W = 20;  // unsigned 4.16 fixed point, post-ReLU
  localparam int ADDR_W = 12;

  localparam logic [2:0] CSEL_NONE = 3'b000;
  localparam logic [2:0] CSEL_L0   = 3'b001;
  localparam logic [2:0] CSEL_L1   = 3'b011;
  localparam logic [2:0] CSEL_L2   = 3'b101;

  localparam int L0_DIM = 64;
  localparam int L1_DIM = 32;
  localparam int L2_DIM = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2
  } state_e;

endpackage

// File: rtl/pool2_flatten_if.sv
// ---------------------------------------------------------------------------
// pool2_flatten_if
// Shared memory-port signalling between a layer engine and layer memories.
//   crd / caddr_rd / cdata_rd : read strobe, address, returned data
//   cwr / caddr_wr / cdata_wr : write strobe, address, data
//   csel                      : selects which layer memory is addressed
// master = engine side, slave = memory side.
// ---------------------------------------------------------------------------
interface pool2_flatten_if #(
  parameter int DATA_W = 20,
  parameter int ADDR_W = 12
);

  logic              crd;
  logic [ADDR_W-1:0] caddr_rd;
  logic [DATA_W-1:0] cdata_rd;
  logic              cwr;
  logic [ADDR_W-1:0] caddr_wr;
  logic [DATA_W-1:0] cdata_wr;
  logic [2:0]        csel;

  modport master (
    output crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel,
    input  cdata_rd
  );

  modport slave (
    input  crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel,
    output cdata_rd
  );

endinterface

// File: rtl/pool_addr_gen.sv
// ---------------------------------------------------------------------------
// pool_addr_gen
// Maps an output position (row r_i, column c_i) and quad index q_i of a
// 2x2 / stride-2 window onto the raster address of the input pixel.
//   q_i[0] selects the right column, q_i[1] the lower row, so q = 0..3 walks
//   base, base+1, base+IN_DIM, base+IN_DIM+1.
// Ports: r_i, c_i (OUT_W bits), q_i (2 bits) -> addr_o (ADDR_W bits).
// ---------------------------------------------------------------------------
module pool_addr_gen #(
  parameter int ADDR_W = 12,
  parameter int IN_DIM = 32,
  parameter int OUT_W  = 4
) (
  input  logic [OUT_W-1:0]  r_i,
  input  logic [OUT_W-1:0]  c_i,
  input  logic [1:0]        q_i,
  output logic [ADDR_W-1:0] addr_o
);

  localparam int IN_W = $clog2(IN_DIM);

  // (2r + q[1]) * IN_DIM + (2c + q[0]), with IN_DIM a power of two
  assign addr_o = (ADDR_W'(r_i)    << (IN_W + 1))
                + (ADDR_W'(q_i[1]) << IN_W)
                + (ADDR_W'(c_i)    << 1)
                +  ADDR_W'(q_i[0]);

endmodule

// File: rtl/pool2_flatten.sv
// ---------------------------------------------------------------------------
// pool2_flatten
// Second-level 2x2 / stride-2 max-pool. Reads the IN_DIM x IN_DIM layer-1 map,
// writes the (IN_DIM/2)^2 result in raster order to layer-2 memory, and tracks
// the global maximum with its flattened index (lowest index wins ties).
// Each output takes 4 read cycles and 1 write cycle.
// Ports:
//   clk      : clock, rising edge
//   reset    : synchronous, active-low
//   ready    : start request, sampled only while idle
//   busy     : high while a run is in progress
//   mem      : shared memory port (master side)
//   gmax     : global maximum of the output map
//   gmax_idx : flattened index of gmax
// ---------------------------------------------------------------------------
module pool2_flatten
  import cnn_pkg::*;
#(
  parameter int DATA_W = cnn_pkg::DATA_W,
  parameter int ADDR_W = cnn_pkg::ADDR_W,
  parameter int IN_DIM = L1_DIM
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ready,
  output logic              busy,
  pool2_flatten_if.master   mem,
  output logic [DATA_W-1:0] gmax,
  output logic [7:0]        gmax_idx
);

  localparam int OUT_DIM = IN_DIM / 2;
  localparam int OUT_W   = $clog2(OUT_DIM);
  localparam int K_W     = 2 * OUT_W;
  localparam logic [K_W-1:0] K_LAST = K_W'(OUT_DIM * OUT_DIM - 1);

  state_e            state_q, state_d;
  logic [K_W-1:0]    k_q, k_d;        // flattened output index {r, c}
  logic [1:0]        q_q, q_d;        // position inside the 2x2 window
  logic [DATA_W-1:0] max_q, max_d;    // running max of the current window
  logic [DATA_W-1:0] gmax_q, gmax_d;
  logic [7:0]        gidx_q, gidx_d;

  logic [ADDR_W-1:0] rd_addr;

  pool_addr_gen #(
    .ADDR_W (ADDR_W),
    .IN_DIM (IN_DIM),
    .OUT_W  (OUT_W)
  ) u_addr_gen (
    .r_i    (k_q[K_W-1:OUT_W]),
    .c_i    (k_q[OUT_W-1:0]),
    .q_i    (q_q),
    .addr_o (rd_addr)
  );

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: the window max is reset too, so cdata_wr and gmax never expose
      // stale data after reset even though they are only meaningful later.
      state_q <= S_IDLE;
      k_q     <= '0;
      q_q     <= '0;
      max_q   <= '0;
      gmax_q  <= '0;
      gidx_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      q_q     <= q_d;
      max_q   <= max_d;
      gmax_q  <= gmax_d;
      gidx_q  <= gidx_d;
    end
  end

  always_comb begin
    // NOTE: every next-state variable holds by default, so no path through
    // the case statement can infer a latch.
    state_d = state_q;
    k_d     = k_q;
    q_d     = q_q;
    max_d   = max_q;
    gmax_d  = gmax_q;
    gidx_d  = gidx_q;

    unique case (state_q)
      S_IDLE: begin
        if (ready) begin
          state_d = S_RD;
          k_d     = '0;
          q_d     = '0;
          gmax_d  = '0;
          gidx_d  = '0;
        end
      end

      S_RD: begin
        // First pixel of a window loads unconditionally; later ones compete.
        if (q_q == 2'd0 || mem.cdata_rd > max_q) max_d = mem.cdata_rd;
        q_d = q_q + 2'd1;  // wraps to 0 for the next window
        if (q_q == 2'd3) state_d = S_WR;
      end

      S_WR: begin
        // Strictly greater keeps the lowest index on ties.
        if (max_q > gmax_q) begin
          gmax_d = max_q;
          gidx_d = 8'(k_q);
        end
        if (k_q == K_LAST) begin
          state_d = S_IDLE;
        end else begin
          k_d     = k_q + K_W'(1);
          state_d = S_RD;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode directly from registered state; address and data buses
  // are zeroed outside their strobe cycle.
  assign busy         = (state_q != S_IDLE);
  assign mem.crd      = (state_q == S_RD);
  assign mem.cwr      = (state_q == S_WR);
  assign mem.csel     = (state_q == S_RD) ? CSEL_L1 :
                        (state_q == S_WR) ? CSEL_L2 : CSEL_NONE;
  assign mem.caddr_rd = (state_q == S_RD) ? rd_addr : '0;
  assign mem.caddr_wr = (state_q == S_WR) ? ADDR_W'(k_q) : '0;
  assign mem.cdata_wr = (state_q == S_WR) ? max_q : '0;
  assign gmax         = gmax_q;
  assign gmax_idx     = gidx_q;

endmodule

// File: tb/tb_pool2_flatten.sv
// ---------------------------------------------------------------------------
// tb_pool2_flatten
// Directed bench for pool2_flatten: behavioural layer-1/layer-2 memories on
// the shared port, a strobe/csel/write-timing monitor, and a linear sequence
// of reset, ramp, constant, spike, quad-sweep and mid-run-reset steps.
// ---------------------------------------------------------------------------
module tb_pool2_flatten;
  import cnn_pkg::*;

  localparam logic [19:0] SENT = 20'hDEAD0;

  logic              clk = 1'b0;
  logic              reset;
  logic              ready;
  logic              busy;
  logic [DATA_W-1:0] gmax;
  logic [7:0]        gmax_idx;

  pool2_flatten_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) mem_if ();

  pool2_flatten #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .IN_DIM(L1_DIM)) dut (
    .clk      (clk),
    .reset    (reset),
    .ready    (ready),
    .busy     (busy),
    .mem      (mem_if),
    .gmax     (gmax),
    .gmax_idx (gmax_idx)
  );

  always #5 clk = ~clk;

  logic [19:0] l1 [1024];
  logic [19:0] l2 [256];

  int errors = 0;
  int checks = 0;
  int busy_cnt = 0;
  int strobe_cnt = 0;
  int overlap_err = 0;
  int csel_err = 0;
  int timing_err = 0;

  // Memory model and protocol monitor, all on the falling edge.
  always @(negedge clk) begin
    logic [2:0] exp_sel;
    if (mem_if.crd === 1'b1) mem_if.cdata_rd = l1[mem_if.caddr_rd[9:0]];
    if (mem_if.cwr === 1'b1) l2[mem_if.caddr_wr[7:0]] = mem_if.cdata_wr;
    if (mem_if.crd === 1'b1 || mem_if.cwr === 1'b1) strobe_cnt++;
    if (mem_if.crd === 1'b1 && mem_if.cwr === 1'b1) overlap_err++;
    exp_sel = (mem_if.crd === 1'b1) ? CSEL_L1 :
              (mem_if.cwr === 1'b1) ? CSEL_L2 : CSEL_NONE;
    if (mem_if.csel !== exp_sel) csel_err++;
    if (mem_if.cwr === 1'b1 && busy_cnt != 5 * int'(mem_if.caddr_wr) + 4) timing_err++;
    if (busy === 1'b1) busy_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference 2x2 max over the current l1 contents.
  function automatic logic [19:0] pool_ref(input int k);
    int r = k / 16;
    int c = k % 16;
    logic [19:0] m = 20'h0;
    for (int dy = 0; dy < 2; dy++)
      for (int dx = 0; dx < 2; dx++)
        if (l1[(2 * r + dy) * 32 + 2 * c + dx] > m) m = l1[(2 * r + dy) * 32 + 2 * c + dx];
    return m;
  endfunction

  task automatic start_run(input string tag, input bit hold_ready);
    for (int i = 0; i < 256; i++) l2[i] = SENT;
    busy_cnt = 0;
    @(posedge clk); #1;
    ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_busy_rise"}, 32'(busy), 32'd1);
    if (!hold_ready) ready = 1'b0;
  endtask

  task automatic run_full(input string tag, input logic [19:0] exp_gmax,
                          input logic [7:0] exp_idx, input bit hold_ready);
    int n = 0;
    int bad = 0;
    start_run(tag, hold_ready);
    while (busy === 1'b1 && n < 1500) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_done"}, 32'(busy), 32'd0);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd1280);
    check({tag, "_gmax"}, 32'(gmax), 32'(exp_gmax));
    check({tag, "_gmax_idx"}, 32'(gmax_idx), 32'(exp_idx));
    for (int k = 0; k < 256; k++) if (l2[k] !== pool_ref(k)) bad++;
    check({tag, "_l2_mismatches"}, 32'(bad), 32'd0);
  endtask

  initial begin
    int s;
    int n;

    // Reset held for 3 cycles with ready asserted.
    reset = 1'b0;
    ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_crd", 32'(mem_if.crd), 32'd0);
    check("rst_cwr", 32'(mem_if.cwr), 32'd0);
    check("rst_csel", 32'(mem_if.csel), 32'd0);
    check("rst_caddr_rd", 32'(mem_if.caddr_rd), 32'd0);
    check("rst_caddr_wr", 32'(mem_if.caddr_wr), 32'd0);
    check("rst_cdata_wr", 32'(mem_if.cdata_wr), 32'd0);
    check("rst_gmax", 32'(gmax), 32'd0);
    check("rst_gmax_idx", 32'(gmax_idx), 32'd0);
    check("rst_strobes", 32'(strobe_cnt), 32'd0);
    ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Ramp.
    for (int i = 0; i < 1024; i++) l1[i] = 20'(i);
    run_full("ramp", 20'h003FF, 8'd255, 1'b0);
    check("ramp_l2_0", 32'(l2[0]), 32'h00021);
    check("ramp_l2_17", 32'(l2[17]), 32'h00063);
    check("ramp_l2_255", 32'(l2[255]), 32'h003FF);
    repeat (3) @(posedge clk);
    #1;
    check("ramp_gmax_hold", 32'(gmax), 32'h003FF);

    // Constant map with ready held high: ties keep index 0, and the still-high
    // ready restarts immediately with gmax cleared.
    for (int i = 0; i < 1024; i++) l1[i] = 20'h00010;
    run_full("const", 20'h00010, 8'd0, 1'b1);
    check("const_l2_200", 32'(l2[200]), 32'h00010);
    @(posedge clk); #1;
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_gmax_clr", 32'(gmax), 32'd0);
    ready = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", 32'(busy), 32'd0);
    reset = 1'b1;

    // Single spike.
    for (int i = 0; i < 1024; i++) l1[i] = 20'h0;
    l1[66] = 20'hFFFFF;
    run_full("spike", 20'hFFFFF, 8'd17, 1'b0);
    check("spike_l2_17", 32'(l2[17]), 32'hFFFFF);
    check("spike_l2_16", 32'(l2[16]), 32'h0);
    check("spike_l2_18", 32'(l2[18]), 32'h0);

    // Quad-position sweep: winner sits at window position k mod 4.
    for (int i = 0; i < 1024; i++) l1[i] = 20'h00001;
    for (int k = 0; k < 256; k++) begin
      int p = k % 4;
      l1[(2 * (k / 16) + p / 2) * 32 + 2 * (k % 16) + p % 2] = 20'h00100 + 20'(k);
    end
    run_full("sweep", 20'h001FF, 8'd255, 1'b0);
    check("sweep_l2_1", 32'(l2[1]), 32'h00101);
    check("sweep_l2_2", 32'(l2[2]), 32'h00102);
    check("sweep_l2_3", 32'(l2[3]), 32'h00103);
    check("sweep_l2_254", 32'(l2[254]), 32'h001FE);

    // Reset asserted during cycle 600 of a ramp run.
    for (int i = 0; i < 1024; i++) l1[i] = 20'(i);
    start_run("midrst", 1'b0);
    n = 0;
    while (busy_cnt < 600 && n < 1500) begin
      @(posedge clk); #1;
      n++;
    end
    check("midrst_reached_600", 32'(busy_cnt), 32'd600);
    reset = 1'b0;
    @(posedge clk); #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_crd", 32'(mem_if.crd), 32'd0);
    check("midrst_cwr", 32'(mem_if.cwr), 32'd0);
    s = strobe_cnt;
    repeat (10) @(posedge clk);
    #1;
    check("midrst_busy_hold", 32'(busy), 32'd0);
    check("midrst_no_strobes", 32'(strobe_cnt), 32'(s));
    check("midrst_l2_119", 32'(l2[119]), 32'h001EF);
    check("midrst_l2_120", 32'(l2[120]), 32'(SENT));
    reset = 1'b1;
    @(posedge clk);
    run_full("rerun", 20'h003FF, 8'd255, 1'b0);
    check("rerun_l2_17", 32'(l2[17]), 32'h00063);

    // Protocol monitor totals.
    check("strobe_overlap", 32'(overlap_err), 32'd0);
    check("csel_vs_strobe", 32'(csel_err), 32'd0);
    check("write_cycle_5k4", 32'(timing_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pool2_flatten.md
# pool2_flatten

Second-level pooling stage that sits directly downstream of `CONV`. After `CONV` has filled the layer-1 max-pool memory (32×32 map, `csel` 3'b011), this block reads that map through the same shared memory-port signalling. It applies a 2×2 / stride-2 max-pool and writes the 16×16 result, flattened in raster order, to layer-2 memory (`csel` 3'b101). It also reports the global maximum and its flattened index.

## Interface
Parameters:
- `DATA_W`, 20: pixel width, unsigned (post-ReLU 4.16 fixed point)
- `ADDR_W`, 12: memory address width
- `IN_DIM`, 32: input map side length; output side is `IN_DIM/2`

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-low (0 = reset)
- `ready`  in  1  start request, sampled in IDLE
- `busy`  out  1  high while processing
- `crd`  out  1  memory read strobe
- `caddr_rd`  out  ADDR_W  read address
- `cdata_rd`  in  DATA_W  read data; the memory updates it on the falling edge of a `crd` cycle
- `cwr`  out  1  memory write strobe
- `caddr_wr`  out  ADDR_W  write address
- `cdata_wr`  out  DATA_W  write data
- `csel`  out  3  memory select: 3'b011 on read cycles, 3'b101 on write cycles, 3'b000 otherwise
- `gmax`  out  DATA_W  global maximum of the output map
- `gmax_idx`  out  8  flattened index of `gmax`

## Operation
- States: IDLE, RD, WR.
- IDLE → RD when `ready`=1. `busy` rises on the same edge. Output index k, output row r and output column c, and quad counter q all start at 0.
- Input addresses in RD, for q=0..3: `2r*32+2c`, `+1`, `+32`, `+33`.
  - Each RD cycle drives `crd`=1, `csel`=011 and `caddr_rd`.
  - On the edge that ends the cycle, the block registers `cdata_rd` into the running max.
  - At q=0 the running max is loaded unconditionally; at q=1..3 the larger value is kept (unsigned compare).
- RD(q=3) → WR. The WR cycle drives `cwr`=1, `csel`=101, `caddr_wr`=k and `cdata_wr`=running max.
- Global max update in the WR cycle: `gmax`/`gmax_idx` update only when the new value is strictly greater than `gmax`, so ties keep the lowest index.
- WR → RD for k+1. After k=255, WR → IDLE and `busy` falls.
- `crd` and `cwr` are never high in the same cycle.
- `ready` is ignored while `busy`=1. `ready` still high in IDLE after completion starts a new run.
- A new run clears `gmax` to 0 and `gmax_idx` to 0 on the start edge. Both otherwise hold their value from the end of a run until the next start.

## Timing
- Reset values (at the edge where `reset`=0): `busy` 0, `crd` 0, `cwr` 0, `csel` 000, `caddr_rd` 0, `caddr_wr` 0, `cdata_wr` 0, `gmax` 0, `gmax_idx` 0, state IDLE.
- Read latency is 1 cycle: the address is driven in cycle t and the data is captured at the end of cycle t.
- Each output takes 5 cycles (4 RD + 1 WR). Output k is written in cycle 5k+4, counting cycle 0 as the first cycle after `busy` rises.
- `busy` is high for exactly 1280 cycles.
- Reset asserted mid-run: at that edge all outputs return to reset values and no further read or write is issued. Partially written layer-2 contents are left as they are.

## Structure
- Shared package `cnn_pkg` holds:
  - `DATA_W`, `ADDR_W`
  - `CSEL_L0`=3'b001, `CSEL_L1`=3'b011, `CSEL_L2`=3'b101
  - map dimensions 64/32/16
  - the state enum
- One sub-module, `pool_addr_gen`: combinational map from (r, c, q) to `caddr_rd`, using shifts and adds only. The FSM, counters, running max and global-max registers stay in the top level.

## Test plan
- Reset: drive `reset`=0 for 3 cycles with `ready`=1 → every output equals its reset value and no strobes are seen.
- Ramp:
  - Stimulus: L1[i]=i, i=0..1023.
  - Required layer-2 contents: L2[0]=0x00021, L2[17]=0x00063, L2[255]=0x003FF.
  - Required global result: `gmax`=0x003FF, `gmax_idx`=255.
  - Required timing: `busy` high 1280 cycles.
- Constant map: all L1=0x00010 → all L2=0x00010, `gmax`=0x00010, `gmax_idx`=0 (tie rule).
- Spike: L1[66]=0xFFFFF, all other L1=0 → L2[17]=0xFFFFF, all other L2=0, `gmax_idx`=17.
- Quad-position sweep:
  - Stimulus: for output k, place 0x00100+k at quad position k mod 4 and 0x00001 elsewhere.
  - Required: L2[k]=0x00100+k for every k.
  - Also check: `crd`/`cwr` never overlap, and `csel` matches the strobe in every cycle.
- Reset mid-run: assert `reset`=0 in cycle 600 → `busy`/`crd`/`cwr` are 0 from that edge on. A fresh start afterwards with the ramp data yields the full ramp result.
